// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default clock/baud
// settings, reused by both the transmitter and the matching receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int DEF_CLK_FREQ_HZ = 27_000_000;
   localparam int DEF_BAUD_RATE   = 115_200;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. A synchronous clear parks the count at zero.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic bit_end_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last    = (r_cnt == CNT_LAST);
   assign bit_end_o = w_last;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a show-ahead FIFO: pops one word per frame and
// serialises it as start bit, DATA_WIDTH bits LSB first, and one stop bit.
//
//   state | meaning
//   IDLE  | line high, waiting for a word in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | data bits, LSB first, one bit period each
//   STOP  | stop bit (high); may pop the next word on its last cycle
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int BAUD_RATE   = DEF_BAUD_RATE,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  empty_i,
   output logic                  rd_o,
   output logic                  tx_o,
   output logic                  busy_o
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
      end
      if (DATA_WIDTH < 2) begin : g_bad_width
         $error("uart_tx: DATA_WIDTH must be at least 2");
      end
   endgenerate

   uart_state_t           r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BIT_W-1:0]      r_bit;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_bit_end;
   logic                  w_pop;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (r_state == IDLE),
      .bit_end_o(w_bit_end)
   );

   // The pop must coincide with the capture edge of the show-ahead word, so
   // it is decoded from registered state rather than registered itself.
   assign w_pop = !rst_i && !empty_i &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

   assign rd_o   = w_pop;
   assign tx_o   = r_tx;
   assign busy_o = r_busy;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift <= rdata_i;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_tx    <= r_shift[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_bit == BIT_LAST) begin
                     r_bit   <= '0;
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift <= rdata_i;
                     r_bit   <= '0;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit, with a queue standing in
// for the show-ahead FIFO.
module tb_uart_tx;

   localparam int CLK_HZ = 460_800;
   localparam int BAUD   = 115_200;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [7:0] rdata_i;
   logic       empty_i;
   logic       rd_o;
   logic       tx_o;
   logic       busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] fifo_q[$];
   logic       tx_tr   [0:199];
   logic       rd_tr   [0:199];
   logic       busy_tr [0:199];

   uart_tx #(
      .CLK_FREQ_HZ(CLK_HZ),
      .BAUD_RATE  (BAUD),
      .DATA_WIDTH (8)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .rdata_i(rdata_i),
      .empty_i(empty_i),
      .rd_o   (rd_o),
      .tx_o   (tx_o),
      .busy_o (busy_o)
   );

   always #5 clk = ~clk;

   task automatic drive_fifo();
      empty_i = (fifo_q.size() == 0);
      rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   // mode 0: inputs follow the queue; 1: garbage data and toggling empty;
   // 2: queue plus a 2-cycle reset at cycles 15-16; 3: inputs held.
   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_tr[i]   = tx_o;
         rd_tr[i]   = rd_o;
         busy_tr[i] = busy_o;
         @(posedge clk);
         #1;
         if (rd_tr[i] === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
         case (mode)
            0: drive_fifo();
            1: begin
               rdata_i = 8'hFF;
               empty_i = (i >= 38) ? 1'b1 : i[0];
            end
            2: begin
               drive_fifo();
               if (i == 14) rst_i = 1'b1;
               else if (i == 16) rst_i = 1'b0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      rst_i   = 1'b1;
      empty_i = 1'b0;
      rdata_i = 8'h77;
      run(4, 3);
      for (int i = 0; i < 4; i++) begin
         n_checks += 3;
         if (rd_tr[i] !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd cyc %0d got %b exp 0", i, rd_tr[i]);
         end
         if (tx_tr[i] !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx cyc %0d got %b exp 1", i, tx_tr[i]);
         end
         if (busy_tr[i] !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy cyc %0d got %b exp 0", i, busy_tr[i]);
         end
      end
      rst_i = 1'b0;
      drive_fifo();
   endtask

   task automatic test_empty();
      run(100, 0);
      for (int i = 0; i < 100; i++) begin
         n_checks += 3;
         if (rd_tr[i] !== 1'b0) begin
            n_fail++; $display("FAIL empty_rd cyc %0d got %b exp 0", i, rd_tr[i]);
         end
         if (tx_tr[i] !== 1'b1) begin
            n_fail++; $display("FAIL empty_tx cyc %0d got %b exp 1", i, tx_tr[i]);
         end
         if (busy_tr[i] !== 1'b0) begin
            n_fail++; $display("FAIL empty_busy cyc %0d got %b exp 0", i, busy_tr[i]);
         end
      end
   endtask

   task automatic test_single_byte();
      logic [9:0] slots;
      slots = 10'b1_1010_0101_0;  // stop | A5 MSB..LSB | start
      fifo_q.push_back(8'hA5);
      drive_fifo();
      run(50, 0);
      for (int i = 0; i < 50; i++) begin
         logic exp_tx, exp_busy, exp_rd;
         exp_rd   = (i == 0);
         exp_busy = (i >= 1 && i <= 40);
         exp_tx   = (i >= 1 && i <= 40) ? slots[(i - 1) / 4] : 1'b1;
         n_checks += 3;
         if (rd_tr[i] !== exp_rd) begin
            n_fail++; $display("FAIL single_rd cyc %0d got %b exp %b", i, rd_tr[i], exp_rd);
         end
         if (tx_tr[i] !== exp_tx) begin
            n_fail++; $display("FAIL single_tx cyc %0d got %b exp %b", i, tx_tr[i], exp_tx);
         end
         if (busy_tr[i] !== exp_busy) begin
            n_fail++; $display("FAIL single_busy cyc %0d got %b exp %b", i, busy_tr[i], exp_busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] s0, s1;
      s0 = 10'b1_0101_0101_0;  // 0x55
      s1 = 10'b1_0000_1111_0;  // 0x0F
      fifo_q.push_back(8'h55);
      fifo_q.push_back(8'h0F);
      drive_fifo();
      run(90, 0);
      for (int i = 0; i < 90; i++) begin
         logic exp_tx, exp_busy, exp_rd;
         exp_rd   = (i == 0 || i == 40);
         exp_busy = (i >= 1 && i <= 80);
         if (i >= 1 && i <= 40)       exp_tx = s0[(i - 1) / 4];
         else if (i >= 41 && i <= 80) exp_tx = s1[(i - 41) / 4];
         else                         exp_tx = 1'b1;
         n_checks += 3;
         if (rd_tr[i] !== exp_rd) begin
            n_fail++; $display("FAIL b2b_rd cyc %0d got %b exp %b", i, rd_tr[i], exp_rd);
         end
         if (tx_tr[i] !== exp_tx) begin
            n_fail++; $display("FAIL b2b_tx cyc %0d got %b exp %b", i, tx_tr[i], exp_tx);
         end
         if (busy_tr[i] !== exp_busy) begin
            n_fail++; $display("FAIL b2b_busy cyc %0d got %b exp %b", i, busy_tr[i], exp_busy);
         end
      end
      n_checks += 2;
      if (tx_tr[40] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_stop_edge got %b exp 1", tx_tr[40]);
      end
      if (tx_tr[41] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_start_edge got %b exp 0", tx_tr[41]);
      end
   endtask

   task automatic test_data_stability();
      logic [9:0] slots;
      slots = 10'b1_1010_0101_0;
      fifo_q.push_back(8'hA5);
      drive_fifo();
      run(50, 1);
      for (int i = 1; i <= 40; i++) begin
         n_checks += 2;
         if (tx_tr[i] !== slots[(i - 1) / 4]) begin
            n_fail++; $display("FAIL stable_tx cyc %0d got %b exp %b", i, tx_tr[i], slots[(i - 1) / 4]);
         end
         if (rd_tr[i] !== 1'b0) begin
            n_fail++; $display("FAIL stable_rd cyc %0d got %b exp 0", i, rd_tr[i]);
         end
      end
      n_checks++;
      if (rd_tr[0] !== 1'b1) begin
         n_fail++; $display("FAIL stable_pop got %b exp 1", rd_tr[0]);
      end
      drive_fifo();
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] s81;
      s81 = 10'b1_1000_0001_0;
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'h81);
      drive_fifo();
      run(70, 2);
      for (int i = 0; i <= 17; i++) begin
         logic exp_rd;
         exp_rd = (i == 0 || i == 17);
         n_checks++;
         if (rd_tr[i] !== exp_rd) begin
            n_fail++; $display("FAIL rstmid_rd cyc %0d got %b exp %b", i, rd_tr[i], exp_rd);
         end
      end
      n_checks += 2;
      if (tx_tr[16] !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_tx_abort got %b exp 1", tx_tr[16]);
      end
      if (busy_tr[16] !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_busy_abort got %b exp 0", busy_tr[16]);
      end
      for (int j = 1; j <= 40; j++) begin
         n_checks += 2;
         if (tx_tr[17 + j] !== s81[(j - 1) / 4]) begin
            n_fail++; $display("FAIL rstmid_tx81 cyc %0d got %b exp %b", 17 + j, tx_tr[17 + j], s81[(j - 1) / 4]);
         end
         if (busy_tr[17 + j] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy81 cyc %0d got %b exp 1", 17 + j, busy_tr[17 + j]);
         end
      end
      n_checks++;
      if (busy_tr[58] !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_idle_after got %b exp 0", busy_tr[58]);
      end
   endtask

   task automatic test_fifo_integration();
      logic [7:0] exp_bytes [0:2];
      int         pops;
      exp_bytes[0] = 8'h01;
      exp_bytes[1] = 8'h02;
      exp_bytes[2] = 8'h03;
      fifo_q.push_back(8'h01);
      fifo_q.push_back(8'h02);
      fifo_q.push_back(8'h03);
      drive_fifo();
      run(130, 0);
      pops = 0;
      for (int i = 0; i < 130; i++) if (rd_tr[i] === 1'b1) pops++;
      n_checks += 2;
      if (pops != 3) begin
         n_fail++; $display("FAIL fifo_pop_count got %0d exp 3", pops);
      end
      if (fifo_q.size() != 0) begin
         n_fail++; $display("FAIL fifo_drained got %0d words left exp 0", fifo_q.size());
      end
      for (int f = 0; f < 3; f++) begin
         logic [7:0] got;
         for (int k = 0; k < 8; k++) got[k] = tx_tr[40 * f + 5 + 4 * k + 2];
         n_checks += 3;
         if (got !== exp_bytes[f]) begin
            n_fail++; $display("FAIL fifo_decode frame %0d got %h exp %h", f, got, exp_bytes[f]);
         end
         if (rd_tr[40 * f] !== 1'b1) begin
            n_fail++; $display("FAIL fifo_pop_pos frame %0d got %b exp 1", f, rd_tr[40 * f]);
         end
         if (tx_tr[40 * f + 3] !== 1'b0) begin
            n_fail++; $display("FAIL fifo_start frame %0d got %b exp 0", f, tx_tr[40 * f + 3]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single_byte();
      test_back_to_back();
      test_data_stability();
      test_reset_mid_frame();
      test_fifo_integration();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 Local constant CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUD_RATE, truncated (234 at defaults); CLKS_PER_BIT < 2 is a compile-time error.
REQ-005 clk_i  input  1  single system clock; all logic on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 rdata_i  input  DATA_WIDTH  FIFO head word, show-ahead, valid whenever empty_i is low.
REQ-008 empty_i  input  1  FIFO empty flag.
REQ-009 rd_o  output  1  FIFO pop strobe, one cycle per word.
REQ-010 tx_o  output  1  serial line, idle high, registered.
REQ-011 busy_o  output  1  high whenever a frame is in progress.

Function
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 In IDLE with empty_i low, the block SHALL assert rd_o for that cycle, capture rdata_i into a shift register, and enter START on the next cycle.
REQ-014 tx_o SHALL go low on the cycle after rd_o is asserted. Pop-to-start latency is exactly 1 cycle.
REQ-015 START SHALL drive tx_o low for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 DATA SHALL send DATA_WIDTH bits LSB first, each held for exactly CLKS_PER_BIT cycles. A bit counter of width $clog2(DATA_WIDTH) selects DATA-to-STOP after the last bit.
REQ-017 STOP SHALL drive tx_o high for exactly CLKS_PER_BIT cycles.
REQ-018 On the last STOP cycle:
- if empty_i is low, assert rd_o, capture rdata_i and enter START (back-to-back, no idle gap);
- otherwise enter IDLE.
REQ-019 Every frame SHALL last exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-020 rd_o SHALL NOT be asserted while empty_i is high, and SHALL be asserted at most once per frame.
REQ-021 rd_o SHALL only be asserted in IDLE or on the last STOP cycle.
REQ-022 After capture, changes on rdata_i and empty_i SHALL have no effect on the frame in progress.
REQ-023 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary. It SHALL be held at 0 in IDLE.
REQ-024 busy_o SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 tx_o SHALL be driven from a flop, so no combinational glitches reach the pin.

Reset
REQ-026 While rst_i is sampled high, the block SHALL hold: state=IDLE, tx_o=1, rd_o=0, busy_o=0, baud and bit counters=0, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx_o SHALL be high on the cycle after rst_i is sampled, and the already-popped word is discarded.
REQ-028 No rd_o SHALL be issued during any cycle in which rst_i is high, regardless of empty_i.
REQ-029 The first pop after reset release SHALL occur no earlier than the first cycle with rst_i low.

Structure
REQ-030 Shared package uart_pkg SHALL hold:
- the state typedef uart_state_t (IDLE, START, DATA, STOP);
- default CLK_FREQ_HZ and BAUD_RATE constants, for reuse by the matching receiver.
REQ-031 The baud counter SHALL be a sub-module uart_baud_tick. It has a synchronous clear and produces a one-cycle bit_end pulse every CLKS_PER_BIT cycles.
REQ-032 Shift register, bit counter and FSM SHALL remain in uart_tx.

Verification (bench: CLK_FREQ_HZ=460800, BAUD_RATE=115200, so CLKS_PER_BIT=4)
REQ-033 Single byte: FIFO holds 0xA5, empty_i low.
- Expect rd_o for 1 cycle.
- Then tx_o = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles, 40 cycles total.
- busy_o high for exactly those 40 cycles.
REQ-034 Back-to-back: FIFO holds 0x55 then 0x0F.
- Expect two rd_o pulses exactly 40 cycles apart.
- Start bit of 0x0F immediately follows the stop bit of 0x55.
REQ-035 Empty: empty_i held high for 100 cycles.
- Expect rd_o never asserted, tx_o=1, busy_o=0 throughout.
REQ-036 Data stability: after popping 0xA5, rdata_i forced to 0xFF and empty_i toggled mid-frame.
- Expect the serial bits to still encode 0xA5.
- Expect no extra rd_o before the last STOP cycle.
REQ-037 Reset mid-frame: rst_i high for 2 cycles at cycle 15 of a frame, with empty_i low.
- Expect tx_o=1 and busy_o=0 from the next cycle, and no rd_o during reset.
- After release, the next word starts with rd_o on the first cycle with rst_i low.
REQ-038 Integration with the team FIFO: write 0x01, 0x02, 0x03 into the FIFO.
- Expect the serial decode to give 0x01, 0x02, 0x03 in order.
- Expect exactly 3 rd_o pulses, and the FIFO empty after the third.
